div_unit: RTL



---
 rtl/div_unit_pkg.sv | 12 +
 rtl/div_unit_step.sv | 26 ++
 rtl/div_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared divider constants: fixed start-to-done latency and sequencer state encodings.
package div_unit_pkg;

    localparam int DIV_LATENCY = 17;

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_IDLE = 2'd0;
    localparam div_state_t DIV_CALC = 2'd1;
    localparam div_state_t DIV_FIX  = 2'd2;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   prem_in,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   prem_out,
    output logic             qbit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvs_ext;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    always_comb begin
        shifted  = {prem_in, dbit};
        dvs_ext  = {2'b00, divisor};
        diff     = shifted - dvs_ext;
        borrow   = (shifted < dvs_ext);
        prem_out = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
        qbit     = ~borrow;
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 16-bit signed/unsigned divider, one quotient bit per clock, start/busy/done handshake.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Magnitude of 0x8000 stays 0x8000, which is exactly what the overflow case needs.
    function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v, input logic neg);
        logic signed [WIDTH-1:0] vs;
        vs = v;
        return neg ? -vs : vs;
    endfunction

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dreg;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] dvs;
    logic             qneg;
    logic             rneg;
    logic             dz;
    logic [WIDTH:0]   prem_next;
    logic             qbit;
    logic             dvd_neg;
    logic             dvs_neg;

    assign busy    = (state != DIV_IDLE);
    assign dvd_neg = signed_op & dividend[WIDTH-1];
    assign dvs_neg = signed_op & divisor[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem_in  (prem),
        .dbit     (dreg[WIDTH-1]),
        .divisor  (dvs),
        .prem_out (prem_next),
        .qbit     (qbit)
    );

    // Datapath registers: no reset, they are always reloaded on start.
    always_ff @(posedge clk) begin
        case (state)
            DIV_IDLE: begin
                if (start) begin
                    dreg <= mag(dividend, dvd_neg);
                    dvs  <= mag(divisor, dvs_neg);
                    prem <= '0;
                    qneg <= dvd_neg ^ dvs_neg;
                    rneg <= dvd_neg;
                    dz   <= (divisor == '0);
                end
            end
            DIV_CALC: begin
                dreg <= {dreg[WIDTH-2:0], qbit};
                prem <= prem_next;
            end
            default: ;
        endcase
    end

    // Sequencer and architecturally visible outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DIV_IDLE;
            cnt         <= '0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state <= DIV_CALC;
                        cnt   <= CNT_W'(WIDTH - 1);
                    end
                end
                DIV_CALC: begin
                    if (cnt == '0) begin
                        state <= DIV_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV_FIX: begin
                    // Divide by zero yields all-ones quotient; remainder already equals the dividend.
                    quot        <= dz ? '1 : fix_sign(dreg, qneg);
                    rem         <= fix_sign(prem[WIDTH-1:0], rneg);
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    state       <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule
